onchip_mem_arbiter: RTL
=======================

Name: onchip_mem_arbiter

Overview:
Two-port Avalon-MM arbiter that shares one single-port on-chip RAM (1024 x 32, byte-enabled, 1-cycle read latency) between two masters. Typical pairing is the HPS/CPU bridge on m0 and the framebuffer pixel fetcher on m1. It uses round-robin arbitration with a bounded hold count, so a streaming master can issue short bursts without starving the other. It drives the RAM's address, byteenable, chipselect, write, writedata and clken pins, and returns readdata with readdatavalid to the owning master.

Parameters:
ADDR_W, 10, word address width; RAM depth = 2**ADDR_W
DATA_W, 32, data width; byteenable width = DATA_W/8
HOLD_MAX, 4, max consecutive grants to one master while the other is requesting (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  DATA_W/8  master 0 byte lanes
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data strobe
m1_*  same set as m0_*, for master 1
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  DATA_W/8  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken
mem_readdata  in  DATA_W  from RAM, valid 1 cycle after the read is issued

Behaviour:
- Request: mN_req = mN_read | mN_write. read and write both high on one master is illegal; treat it as a write and flag it with an assertion in simulation.
- Registered state:
  - ready: cleared by reset, set on the first clk after reset release.
  - last (0/1): owner of the previous grant; resets to 1, so m0 wins first.
  - hold_cnt (4 bit): resets to 0.
  - rd_pend, rd_owner: the read-return pipe; both reset to 0.
- Grant is combinational, evaluated every cycle when ready=1:
  - Only one master requesting: that master wins.
  - Both requesting, hold_cnt < HOLD_MAX: the master equal to last wins (continuation).
  - Both requesting, hold_cnt == HOLD_MAX: the other master wins.
  - Fresh contention after an idle cycle: hold_cnt is 0 and last decides. The non-last master wins first, i.e. round-robin.
- hold_cnt update:
  - Increments when the winner equals last and the other master is requesting.
  - Resets to 1 on a switch.
  - Resets to 0 on an idle cycle.
  - Saturates at HOLD_MAX.
  - last <= winner on every grant.
- Outputs:
  - mN_waitrequest = ~ready | (mN_req & ~grantN). While idle and ready it is 0.
  - Winner's address, byteenable, write and writedata go straight to mem_*.
  - mem_chipselect = grant0 | grant1.
  - mem_write = the winner's write.
  - mem_clken = 1 whenever ready.
- Read return:
  - A granted read sets rd_pend=1 and rd_owner=winner for the next cycle.
  - In that cycle mN_readdatavalid = rd_pend & (rd_owner==N), and mN_readdata = mem_readdata.
  - Back-to-back reads give one result per cycle, in order.
  - Writes generate no readdatavalid.
- Throughput: one transfer per cycle. Fixed read latency of 1 cycle from acceptance (waitrequest low with read high).
- Reset values while reset_n=0:
  - Both waitrequests are 1.
  - Both readdatavalids are 0.
  - mem_chipselect, mem_write and mem_clken are 0.
  - mem_address, byteenable and writedata are 0.
- Reset asserted mid-read: the pending readdatavalid is dropped. A pending write issued before the reset edge is committed; if it is issued in the same cycle, whether it completes is undefined.
- Simultaneous read by m0 and write by m1 to the same address: serialized by grant order; the loser sees its request after the winner's effect.

Test Plan:
- Reset release → both waitrequests are 1 for the first clk after reset_n rises, then 0. m0 read of addr 0x005 alone → mem_chipselect=1, readdatavalid pulses the next cycle with the RAM contents.
- m0 writes 0xDEADBEEF to 0x010 with byteenable 4'b0011, then reads 0x010 → returns 0xXXXXBEEF, with the upper bytes holding prior contents (preload 0x11223344 → 0x1122BEEF).
- m0 and m1 both read continuously, HOLD_MAX=4 → grants run m0 ×4, m1 ×4, m0 ×4. Each readdatavalid appears on the correct master, one cycle after acceptance, with no gaps on mem_chipselect.
- Contention after idle with last=0 → m1 granted first. With HOLD_MAX=1 → strict alternation 1,0,1,0.
- Pull reset_n low the cycle after an accepted m1 read → m1_readdatavalid stays 0, all outputs take their reset values immediately (asynchronously), and the first grant after release goes to m0.
- m1 reads 0x3FF, then 0x000 back-to-back → two consecutive readdatavalid cycles with the data in order; the address wraps with no aliasing.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter for one single-port on-chip RAM.
// Round-robin with a bounded hold count and a one-deep read-return pipe.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  logic       ready;
  logic       last;
  logic [3:0] hold_cnt;
  logic       rd_pend;
  logic       rd_owner;

  logic req0, req1;
  logic any, win;
  logic grant0, grant1;
  logic sel_read, sel_write;
  logic other_req;
  logic issue_read;

  // Arbitration: single requester wins; under contention a fresh
  // run (hold 0) or an exhausted run (hold at limit) hands over.
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    any  = 1'b0;
    win  = 1'b0;
    if (ready) begin
      unique case (1'b1)
        (req0 && !req1): begin
          any = 1'b1;
          win = 1'b0;
        end
        (req1 && !req0): begin
          any = 1'b1;
          win = 1'b1;
        end
        (req0 && req1): begin
          any = 1'b1;
          if (hold_cnt == 4'd0 || hold_cnt >= HOLD_LIM)
            win = ~last;
          else
            win = last;
        end
        default: begin
          any = 1'b0;
          win = 1'b0;
        end
      endcase
    end
    grant0 = any & ~win;
    grant1 = any & win;
  end

  // Route the winner onto the RAM pins; idle or reset drives zeros.
  always_comb begin
    sel_read  = win ? m1_read  : m0_read;
    sel_write = win ? m1_write : m0_write;
    other_req = win ? req0     : req1;
    issue_read = any & sel_read & ~sel_write;
    mem_chipselect = any;
    mem_write      = any & sel_write;
    mem_clken      = ready;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (any) begin
      mem_address    = win ? m1_address    : m0_address;
      mem_byteenable = win ? m1_byteenable : m0_byteenable;
      mem_writedata  = win ? m1_writedata  : m0_writedata;
    end
  end

  // Master-side handshake and read return.
  always_comb begin
    m0_waitrequest   = ~ready | (req0 & ~grant0);
    m1_waitrequest   = ~ready | (req1 & ~grant1);
    m0_readdatavalid = rd_pend & ~rd_owner;
    m1_readdatavalid = rd_pend & rd_owner;
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
  end

  // Arbiter state: ready flag, last owner, hold count, read pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready    <= 1'b0;
      last     <= 1'b1;
      hold_cnt <= 4'd0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      ready   <= 1'b1;
      rd_pend <= issue_read;
      if (issue_read)
        rd_owner <= win;
      if (!any) begin
        hold_cnt <= 4'd0;
      end else begin
        last <= win;
        if (win != last)
          hold_cnt <= 4'd1;
        else if (!other_req)
          hold_cnt <= 4'd1;
        else if (hold_cnt < HOLD_LIM)
          hold_cnt <= hold_cnt + 4'd1;
      end
    end
  end

  // Read and write together on one master is illegal.
  m0_rw_excl: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(m0_read && m0_write));
  m1_rw_excl: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(m1_read && m1_write));

endmodule
